pdu_bufwriter: RTL

// Producer end of the to_pdubuf interface consumed by the PDU. Accepts a serial stream of per-logical-qubit

---
 rtl/pdu_bufwriter_if.sv | 57 +++++
 rtl/pdu_bufwriter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pdu_bufwriter_if.sv
// -----------------------------------------------------------------------------
// pdu_bufwriter_if
//   Bundles the fragment stream from the instruction decoder and the to_pdubuf
//   read side used by the PDU into a single interface.
//
//   Fragment side : in_valid, in_ready, in_opcode, in_lqvalid, in_lqaddr,
//                   in_lpp, in_op, in_mreg, in_last
//   PDU side      : to_pdubuf_rd_en, to_pdubuf_dout, to_pdubuf_empty,
//                   to_pdubuf_full, to_pdubuf_count
//   Status        : err_lqaddr
//
//   modport master : the decoder / PDU environment (drives fragments and rd_en)
//   modport slave  : pdu_bufwriter itself
// -----------------------------------------------------------------------------
interface pdu_bufwriter_if #(
    parameter int NUM_LQ    = 4,
    parameter int LQADDR_BW = 2,
    parameter int OPCODE_BW = 5,
    parameter int DEPTH     = 4
);
    localparam int ENTRY_W = OPCODE_BW + NUM_LQ * (3 + OPCODE_BW + LQADDR_BW);
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [OPCODE_BW-1:0] in_opcode;
    logic                 in_lqvalid;
    logic [LQADDR_BW-1:0] in_lqaddr;
    logic [1:0]           in_lpp;
    logic [OPCODE_BW-1:0] in_op;
    logic [LQADDR_BW-1:0] in_mreg;
    logic                 in_last;

    logic                 to_pdubuf_rd_en;
    logic [ENTRY_W-1:0]   to_pdubuf_dout;
    logic                 to_pdubuf_empty;
    logic                 to_pdubuf_full;
    logic [CNT_W-1:0]     to_pdubuf_count;

    logic                 err_lqaddr;

    modport master (
        output in_valid, in_opcode, in_lqvalid, in_lqaddr, in_lpp, in_op, in_mreg, in_last,
        output to_pdubuf_rd_en,
        input  in_ready,
        input  to_pdubuf_dout, to_pdubuf_empty, to_pdubuf_full, to_pdubuf_count,
        input  err_lqaddr
    );

    modport slave (
        input  in_valid, in_opcode, in_lqvalid, in_lqaddr, in_lpp, in_op, in_mreg, in_last,
        input  to_pdubuf_rd_en,
        output in_ready,
        output to_pdubuf_dout, to_pdubuf_empty, to_pdubuf_full, to_pdubuf_count,
        output err_lqaddr
    );
endinterface

// File: rtl/pdu_bufwriter.sv
// -----------------------------------------------------------------------------
// pdu_bufwriter
//   Producer end of the to_pdubuf path. Collects per-logical-qubit fragments
//   into one packed {opcode, lqlist, lpplist, oplist, mreglist} entry per
//   instruction and queues finished entries in a first-word-fall-through FIFO
//   that the PDU drains.
//
//   Ports
//     clk  : clock
//     rst  : synchronous active-high reset
//     bus  : pdu_bufwriter_if.slave
//            fragment in  : in_valid/in_ready handshake, in_opcode (first
//                           fragment only), in_lqvalid, in_lqaddr, in_lpp,
//                           in_op, in_mreg, in_last
//            PDU out      : to_pdubuf_rd_en, to_pdubuf_dout (head entry, blank
//                           when empty), to_pdubuf_empty/full/count
//            status       : err_lqaddr (sticky out-of-range LQ address)
// -----------------------------------------------------------------------------
module pdu_bufwriter #(
    parameter int NUM_LQ    = 4,
    parameter int LQADDR_BW = 2,
    parameter int OPCODE_BW = 5,
    parameter int DEPTH     = 4
) (
    input logic             clk,
    input logic             rst,
    pdu_bufwriter_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Field order matches the packed bus layout, MSB first.
    typedef struct packed {
        logic [OPCODE_BW-1:0]        opcode;
        logic [NUM_LQ-1:0]           lqlist;
        logic [2*NUM_LQ-1:0]         lpplist;
        logic [NUM_LQ*OPCODE_BW-1:0] oplist;
        logic [NUM_LQ*LQADDR_BW-1:0] mreglist;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,  // no partial instruction
        S_COLLECT = 2'd1,  // partial instruction open
        S_HOLD    = 2'd2   // instruction complete, waiting for FIFO space
    } state_t;

    function automatic entry_t blank_entry();
        entry_t e;
        e.opcode   = '1;   // INVALID opcode
        e.lqlist   = '0;
        e.lpplist  = '0;   // PP_I everywhere
        e.oplist   = '1;
        e.mreglist = '0;
        return e;
    endfunction

    // Out-of-range addresses match no slice, so they leave the entry untouched.
    // A repeated address simply overwrites its slice: last write wins.
    function automatic entry_t merge_frag(
        input entry_t               e,
        input logic                 lqvalid,
        input logic [LQADDR_BW-1:0] lqaddr,
        input logic [1:0]           lpp,
        input logic [OPCODE_BW-1:0] op,
        input logic [LQADDR_BW-1:0] mreg
    );
        entry_t r;
        r = e;
        for (int i = 0; i < NUM_LQ; i++) begin
            if (lqvalid && (int'(lqaddr) == i)) begin
                r.lqlist[i]                              = 1'b1;
                r.lpplist[2*i +: 2]                      = lpp;
                r.oplist[i*OPCODE_BW +: OPCODE_BW]       = op;
                r.mreglist[i*LQADDR_BW +: LQADDR_BW]     = mreg;
            end
        end
        return r;
    endfunction

    state_t            state, state_nxt;
    entry_t            asm_q, asm_nxt;
    entry_t            seed;
    logic              err_q, err_nxt;
    logic              accept;
    logic              lq_bad;
    logic              push;
    logic              pop;

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full, empty;
    entry_t            mem [DEPTH];

    assign bus.in_ready = (state != S_HOLD);
    assign accept       = bus.in_valid && bus.in_ready;
    assign lq_bad       = bus.in_lqvalid && (int'(bus.in_lqaddr) >= NUM_LQ);

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign pop   = bus.to_pdubuf_rd_en && !empty;   // reads on empty are ignored

    // ---------------------------------------------------------------- FSM
    // NOTE: every signal driven here gets a default before the case statement,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        asm_nxt     = asm_q;
        push        = 1'b0;
        seed        = blank_entry();
        seed.opcode = bus.in_opcode;
        err_nxt     = err_q | (accept & lq_bad);

        case (state)
            S_IDLE: begin
                // First fragment starts from a blank entry and fixes the opcode.
                if (accept) begin
                    asm_nxt   = merge_frag(seed, bus.in_lqvalid, bus.in_lqaddr,
                                           bus.in_lpp, bus.in_op, bus.in_mreg);
                    state_nxt = bus.in_last ? S_HOLD : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    asm_nxt = merge_frag(asm_q, bus.in_lqvalid, bus.in_lqaddr,
                                         bus.in_lpp, bus.in_op, bus.in_mreg);
                    if (bus.in_last) begin
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // A full FIFO still accepts the push when the PDU pops in the
                // same cycle, since a slot frees up on that edge.
                if (!full || bus.to_pdubuf_rd_en) begin
                    push      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            asm_q <= blank_entry();
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            asm_q <= asm_nxt;
            err_q <= err_nxt;
        end
    end

    // ---------------------------------------------------------------- FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;   // wraps naturally, DEPTH is 2^n
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; count gates visibility, so stale
    // contents are never observed and the array maps cleanly onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= asm_q;
        end
    end

    always_comb begin
        bus.to_pdubuf_dout = empty ? blank_entry() : mem[rd_ptr];
    end

    assign bus.to_pdubuf_empty = empty;
    assign bus.to_pdubuf_full  = full;
    assign bus.to_pdubuf_count = count;
    assign bus.err_lqaddr      = err_q;

endmodule
